// File: rtl/datapath_seq_ctrl_pkg.sv
// Shared constants for the datapath sequencing controller: instruction field
// positions, opcode/ALU encodings and the FSM state type.
package dp_ctrl_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int OP_MSB  = 12;
    localparam int OP_LSB  = 11;
    localparam int RN_MSB  = 10;
    localparam int RN_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 5;
    localparam int SH_MSB  = 4;
    localparam int SH_LSB  = 3;
    localparam int RM_MSB  = 2;
    localparam int RM_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE_REG = 3'd5,
        S_WRITE_IMM = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    function automatic logic legal_opcode(input logic [2:0] opc, input logic [1:0] op);
        return (opc == OPC_ALU) ||
               ((opc == OPC_MOV) && ((op == MOV_IMM) || (op == MOV_REG)));
    endfunction

endpackage

// File: rtl/datapath_seq_ctrl_dec.sv
// Combinational instruction field extraction: register indices, shift,
// sign-extended immediate and a legality flag.
module instr_field_dec
    import dp_ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic [DW-1:0] instr,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [RW-1:0] rn,
    output logic [RW-1:0] rd,
    output logic [1:0]    sh,
    output logic [RW-1:0] rm,
    output logic [DW-1:0] imm_sext,
    output logic          is_legal
);

    always_comb begin
        opcode   = instr[OPC_MSB:OPC_LSB];
        op       = instr[OP_MSB:OP_LSB];
        rn       = instr[RN_MSB:RN_LSB];
        rd       = instr[RD_MSB:RD_LSB];
        sh       = instr[SH_MSB:SH_LSB];
        rm       = instr[RM_MSB:RM_LSB];
        imm_sext = {{(DW-8){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
        is_legal = legal_opcode(opcode, op);
    end

endmodule

// File: rtl/datapath_seq_ctrl.sv
// Multi-cycle Moore controller sequencing the register-file/shifter/ALU
// datapath through fetch, execute and write-back for one instruction.
module datapath_seq_ctrl #(
    parameter int DW = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [DW-1:0] instr,
    output logic          busy,
    output logic          done,
    output logic          illegal,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          vsel,
    output logic          loada,
    output logic          loadb,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic          loadc,
    output logic          loads,
    output logic [DW-1:0] datapath_in
);
    import dp_ctrl_pkg::*;

    state_t        state_q, state_d;
    logic [DW-1:0] instr_q;
    logic          illegal_q;
    logic [DW-1:0] dp_in_q;

    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn, rd, rm;
    logic [1:0]    sh;
    logic [DW-1:0] imm_sext;
    logic          is_legal;

    instr_field_dec #(.DW(DW), .RW(RW)) u_dec (
        .instr    (instr_q),
        .opcode   (opcode),
        .op       (op),
        .rn       (rn),
        .rd       (rd),
        .sh       (sh),
        .rm       (rm),
        .imm_sext (imm_sext),
        .is_legal (is_legal)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_WAIT;
            illegal_q <= 1'b0;
            dp_in_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_WAIT && start)
                illegal_q <= 1'b0;
            else if (state_q == S_DECODE && !is_legal)
                illegal_q <= 1'b1;
            // Immediate is captured on entry so it is valid throughout WRITE_IMM and held after.
            if (state_d == S_WRITE_IMM)
                dp_in_q <= imm_sext;
        end
    end

    // The instruction latch is data only; it is qualified by state everywhere it is used.
    always_ff @(posedge clk) begin
        if (state_q == S_WAIT && start)
            instr_q <= instr;
    end

    always_comb begin
        state_d  = state_q;
        done     = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state_q)
            S_WAIT: begin
                if (start)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!is_legal)
                    state_d = S_DONE;
                else if (opcode == OPC_MOV)
                    state_d = (op == MOV_IMM) ? S_WRITE_IMM : S_GET_B;
                else
                    state_d = (op == ALU_MVN) ? S_GET_B : S_GET_A;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = S_GET_B;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                shift = sh;
                loadc = 1'b1;
                loads = 1'b1;
                // Single-operand forms zero the A input so the ALU passes or inverts shifted B.
                if (opcode == OPC_MOV) begin
                    asel  = 1'b1;
                    ALUop = ALU_ADD;
                end else if (op == ALU_MVN) begin
                    asel  = 1'b1;
                    ALUop = ALU_MVN;
                end else begin
                    ALUop = op;
                end
                state_d = (opcode == OPC_ALU && op == ALU_SUB) ? S_DONE : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
                state_d  = S_DONE;
            end
            S_WRITE_IMM: begin
                vsel     = 1'b1;
                writenum = rn;
                write    = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign busy        = (state_q != S_WAIT);
    assign illegal     = illegal_q;
    assign datapath_in = dp_in_q;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Bench: controller drives a behavioural datapath; results are compared against
// an instruction-level reference model plus per-instruction strobe expectations.
module tb_datapath_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        busy, done, illegal, write, vsel, loada, loadb, asel, bsel, loadc, loads;
    logic [2:0]  readnum, writenum;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    datapath_seq_ctrl #(.DW(16), .RW(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .busy(busy), .done(done), .illegal(illegal),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
        .datapath_in(datapath_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] shf(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'd0:    return v;
            2'd1:    return v << 1;
            2'd2:    return v >> 1;
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    // Behavioural datapath driven by the controller's strobes.
    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] ra = 16'h0, rb = 16'h0, rc = 16'h0;
    logic        zf = 1'b0;
    logic [15:0] alu_a, alu_b, alu_out;

    always_comb begin
        alu_a = asel ? 16'h0000 : ra;
        alu_b = shf(rb, shift);
        case (ALUop)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a - alu_b;
            2'd2:    alu_out = alu_a & alu_b;
            default: alu_out = ~alu_b;
        endcase
    end

    always @(posedge clk) begin
        if (loada) ra <= rf[readnum];
        if (loadb) rb <= rf[readnum];
        if (loadc) rc <= alu_out;
        if (loads) zf <= (alu_out == 16'h0000);
        if (write) rf[writenum] <= vsel ? datapath_in : rc;
    end

    // Instruction-level reference state.
    logic [15:0] ref_rf [8] = '{default: 16'h0000};
    logic        ref_z = 1'b0;

    task automatic run(input logic [15:0] ins, input string nm);
        logic [2:0]  opc, rn, rd, rm, dst, exp_alu;
        logic [1:0]  op, sh;
        logic [15:0] sext, bval, res;
        int          lat, cyc, na, nb, nw, exp_na, exp_nb, exp_nw;
        bit          ill, seen_done, exp_asel;
        opc  = ins[15:13]; op = ins[12:11]; rn = ins[10:8];
        rd   = ins[7:5];   sh = ins[4:3];   rm = ins[2:0];
        sext = {{8{ins[7]}}, ins[7:0]};
        bval = shf(ref_rf[rm], sh);
        ill = 0; dst = rn; exp_alu = 0; exp_asel = 0;
        exp_na = 0; exp_nb = 1; exp_nw = 1;
        if (opc == 3'b110 && op == 2'b10) begin
            ref_rf[rn] = sext; lat = 3; exp_nb = 0;
        end else if (opc == 3'b110 && op == 2'b00) begin
            ref_rf[rd] = bval; ref_z = (bval == 0); lat = 5; dst = rd; exp_asel = 1;
        end else if (opc == 3'b101) begin
            case (op)
                2'd0: res = ref_rf[rn] + bval;
                2'd1: res = ref_rf[rn] - bval;
                2'd2: res = ref_rf[rn] & bval;
                default: res = ~bval;
            endcase
            ref_z = (res == 0);
            exp_alu = {1'b0, op};
            if (op == 2'd3) begin
                lat = 5; exp_asel = 1; dst = rd; ref_rf[rd] = res;
            end else if (op == 2'd1) begin
                lat = 5; exp_na = 1; exp_nw = 0;
            end else begin
                lat = 6; exp_na = 1; dst = rd; ref_rf[rd] = res;
            end
        end else begin
            ill = 1; lat = 2; exp_nb = 0; exp_nw = 0;
        end

        @(negedge clk);
        instr = ins;
        start = 1'b1;
        cyc = 0; na = 0; nb = 0; nw = 0; seen_done = 0;
        while (!seen_done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            // Scramble inputs while busy: must neither restart nor disturb the latch.
            start = 1'($urandom_range(0, 1));
            instr = 16'($urandom);
            check({nm, " busy"}, busy, 1);
            if (cyc == 1) check({nm, " illegal_cleared"}, illegal, 0);
            if (loada) begin na++; check({nm, " readnum_a"}, readnum, rn); end
            if (loadb) begin nb++; check({nm, " readnum_b"}, readnum, rm); end
            if (!loada && !loadb) check({nm, " readnum_idle"}, readnum, 0);
            if (loadc) begin
                check({nm, " loads_with_c"}, loads, 1);
                check({nm, " shift"}, shift, sh);
                check({nm, " aluop"}, ALUop, exp_alu);
                check({nm, " asel"}, asel, exp_asel);
                check({nm, " bsel"}, bsel, 0);
            end
            if (write) begin
                nw++;
                check({nm, " writenum"}, writenum, dst);
                check({nm, " vsel"}, vsel, (lat == 3));
                if (vsel) check({nm, " datapath_in"}, datapath_in, sext);
            end
            if (done) begin
                seen_done = 1;
                start = 1'b0;
            end
        end
        start = 1'b0;
        check({nm, " latency"}, seen_done ? cyc : 99, lat);
        check({nm, " illegal"}, illegal, ill);
        check({nm, " n_loada"}, na, exp_na);
        check({nm, " n_loadb"}, nb, exp_nb);
        check({nm, " n_write"}, nw, exp_nw);
        check({nm, " reg"}, rf[dst], ref_rf[dst]);
        check({nm, " z"}, zf, ref_z);
        @(negedge clk);
        check({nm, " done_pulse"}, done, 0);
        check({nm, " back_to_wait"}, busy, 0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        logic [2:0]  bad_opc;
        int          k;
        r = 16'($urandom);
        k = $urandom_range(0, 9);
        case (k)
            0: r[15:11] = 5'b110_10;
            1: r[15:11] = 5'b110_00;
            2, 3, 4, 5, 6, 7: r[15:13] = 3'b101;
            8: begin
                bad_opc = 3'($urandom_range(0, 4));
                if (bad_opc == 3'd4) bad_opc = 3'd7;
                r[15:13] = bad_opc;
            end
            default: r[15:11] = ($urandom_range(0, 1) == 0) ? 5'b110_01 : 5'b110_11;
        endcase
        return r;
    endfunction

    initial begin
        logic [15:0] w;
        int          guard;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst illegal", illegal, 0);
        check("rst strobes", {write, vsel, loada, loadb, asel, bsel, loadc, loads}, 0);
        check("rst nums", {readnum, writenum, shift, ALUop}, 0);
        check("rst datapath_in", datapath_in, 0);
        reset_n = 1'b1;

        run(16'hD007, "mov_r0_7");
        run(16'hD102, "mov_r1_2");
        run(16'hA148, "add_r2");
        check("add_r2 value", rf[2], 16'd16);
        run(16'hA901, "cmp_r1_r1");
        check("cmp z set", zf, 1);
        run(16'hD3FF, "mov_r3_m1");
        check("r3 ffff", rf[3], 16'hFFFF);
        run(16'hB883, "mvn_r4_r3");
        check("r4 zero", rf[4], 16'h0000);
        run(16'h0000, "illegal_0000");
        run(16'hD505, "mov_after_illegal");

        // Abort an ADD in GET_B with start held high throughout.
        @(negedge clk);
        instr = 16'hA148;
        start = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!loadb && guard < 10);
        check("abort reached get_b", loadb, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort strobes", {write, loada, loadb, loadc, loads, done}, 0);
        check("abort datapath_in", datapath_in, 0);
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("abort no restart", busy, 0);
        check("abort r2 kept", rf[2], ref_rf[2]);
        run(16'hA148, "add_after_abort");

        for (int i = 0; i < 8; i++) begin
            w = {5'b110_10, 3'(i), 8'($urandom)};
            run(w, "rand_init");
        end
        for (int i = 0; i < 150; i++)
            run(rand_instr(), "rand");

        for (int i = 0; i < 8; i++)
            check("final rf", rf[i], ref_rf[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_seq_ctrl.md
Name: datapath_seq_ctrl

Overview:
Multi-cycle controller that sequences the register-file/shifter/ALU datapath for one 16-bit instruction at a time.
It accepts an instruction through a start/done handshake, decodes it, and drives every datapath control strobe state by state: operand fetch, execute, then write-back.
It sits between the instruction source (test harness now, fetch unit later) and the datapath. It owns the datapath's vsel/loada/loadb/loadc/loads/write/asel/bsel/shift/ALUop/readnum/writenum/datapath_in inputs.

Parameters:
DW, 16, datapath and instruction width
RW, 3, register-index width (8 registers)

Ports:
clk  in  1  rising-edge clock shared with datapath
reset_n  in  1  synchronous active-low reset
start  in  1  request to execute instr; sampled only in WAIT
instr  in  DW  instruction; latched on accepted start
busy  out  1  high in every state except WAIT
done  out  1  one-cycle pulse in DONE state
illegal  out  1  sticky; set on undefined opcode, cleared by reset or next accepted start
readnum  out  RW  register-file read index
writenum  out  RW  register-file write index
write  out  1  register-file write enable
vsel  out  1  1 = write datapath_in, 0 = write C
loada  out  1  load A register
loadb  out  1  load B register
asel  out  1  1 = ALU A input forced to 0, 0 = A register
bsel  out  1  held 0 (B register path)
shift  out  2  shifter control to B
ALUop  out  2  00 ADD, 01 SUB/CMP, 10 AND, 11 MVN
loadc  out  1  load C register
loads  out  1  load status (Z)
datapath_in  out  DW  sign-extended imm8 for MOV-immediate

Behaviour:
- Instruction fields:
  - opcode = instr[15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], imm8 = [7:0].
- Legal instructions:
  - 110/10 MOV Rn,#imm8
  - 110/00 MOV Rd,Rm{sh}
  - 101/00 ADD Rd,Rn,Rm{sh}
  - 101/01 CMP Rn,Rm{sh}
  - 101/10 AND Rd,Rn,Rm{sh}
  - 101/11 MVN Rd,Rm{sh}
- Moore FSM. Outputs are a combinational function of state plus the latched instruction. All strobes default to 0 in every state unless listed below.
- States and transitions:
  - WAIT: start=1 latches instr, clears illegal, goes to DECODE. Otherwise stay.
  - DECODE: no strobes.
    - MOV imm goes to WRITE_IMM.
    - ADD/CMP/AND go to GET_A.
    - MOV reg/MVN go to GET_B.
    - Any other opcode sets illegal and goes to DONE.
  - GET_A: readnum=Rn, loada=1. Next state GET_B.
  - GET_B: readnum=Rm, loadb=1. Next state EXEC.
  - EXEC: shift=sh, bsel=0, loadc=1, loads=1.
    - ADD/CMP/AND: asel=0, ALUop=op.
    - MOV reg: asel=1, ALUop=00.
    - MVN: asel=1, ALUop=11.
    - CMP goes to DONE; all others go to WRITE_REG.
  - WRITE_REG: vsel=0, writenum=Rd, write=1. Next state DONE.
  - WRITE_IMM: datapath_in = {{8{imm8[7]}},imm8}, vsel=1, writenum=Rn, write=1. Next state DONE.
  - DONE: done=1. Next state WAIT.
- Latency, counted from the start-accept edge to the done-high cycle:
  - MOV imm: 3 cycles.
  - MOV reg, MVN: 5 cycles.
  - CMP: 5 cycles.
  - ADD, AND: 6 cycles.
- Outside WRITE_IMM, datapath_in holds its last value. At reset it is 0.
- start while busy is ignored and not queued. The latched instr is stable from accept until WAIT.
- Reset values: state=WAIT; every output 0; illegal=0.
- Reset mid-instruction aborts immediately at that edge. write is 0 in the following cycle, so no partial write-back occurs.
- readnum outside GET_A/GET_B holds 0.

Decomposition:
- Package dp_ctrl_pkg holds:
  - Opcode/op localparams: OPC_MOV=3'b110, OPC_ALU=3'b101, ALU_ADD..ALU_MVN.
  - State encoding: WAIT, DECODE, GET_A, GET_B, EXEC, WRITE_REG, WRITE_IMM, DONE as 3-bit constants.
  - Field bit positions.
- One sub-module, instr_field_dec: purely combinational extraction of opcode/op/Rn/Rd/sh/Rm, sign-extended imm8, and an is_legal flag.

Test Plan:
- MOV R0,#7 (16'hD007), then MOV R1,#2 (16'hD102) -> each has done 3 cycles after accept; REGFILE R0=7, R1=2; illegal=0.
- ADD R2,R1,R0,LSL#1 (16'hA148) after the above -> done at cycle 6; strobe order loada(readnum=1), loadb(readnum=0), loadc+loads(shift=01,ALUop=00), write(writenum=2,vsel=0); R2=16, Z=0.
- CMP R1,R1 (16'hA901) -> done at cycle 5, write never asserted, Z=1, register file unchanged.
- MOV R3,#-1 (16'hD3FF) -> datapath_in=16'hFFFF during WRITE_IMM; R3=16'hFFFF. Then MVN R4,R3 (16'hB883) -> R4=0, Z=1.
- Illegal opcode 16'h0000 -> illegal=1, done at cycle 2, no load/write strobes. Next legal start clears illegal.
- reset_n=0 during GET_B of ADD; start pulsed mid-instruction of a second ADD -> FSM back in WAIT, all strobes 0, R2 unchanged. The start pulsed while busy has no effect.
